// File: rtl/keccak_pkg.sv
// Definitions shared by the Keccak input and output buffers: mode encoding,
// per-mode rate/digest geometry and the lane byte-order helper.
package keccak_pkg;

  localparam int KECCAK_LANE_W    = 64;
  localparam int KECCAK_MAX_LANES = 21;

  typedef enum logic [2:0] {
    MODE_SHA3_224  = 3'd0,
    MODE_SHA3_256  = 3'd1,
    MODE_SHA3_384  = 3'd2,
    MODE_SHA3_512  = 3'd3,
    MODE_SHAKE_128 = 3'd4,
    MODE_SHAKE_256 = 3'd5
  } mode_e;

  // Unassigned encodings fall back to SHA3-256.
  function automatic mode_e decode_mode(input logic [2:0] raw);
    mode_e m;
    case (raw)
      3'd0:    m = MODE_SHA3_224;
      3'd1:    m = MODE_SHA3_256;
      3'd2:    m = MODE_SHA3_384;
      3'd3:    m = MODE_SHA3_512;
      3'd4:    m = MODE_SHAKE_128;
      3'd5:    m = MODE_SHAKE_256;
      default: m = MODE_SHA3_256;
    endcase
    return m;
  endfunction

  function automatic logic is_shake(input mode_e m);
    return (m == MODE_SHAKE_128) || (m == MODE_SHAKE_256);
  endfunction

  function automatic logic [4:0] rate_words(input mode_e m);
    logic [4:0] r;
    case (m)
      MODE_SHA3_224:  r = 5'd18;
      MODE_SHA3_256:  r = 5'd17;
      MODE_SHA3_384:  r = 5'd13;
      MODE_SHA3_512:  r = 5'd9;
      MODE_SHAKE_128: r = 5'd21;
      MODE_SHAKE_256: r = 5'd17;
      default:        r = 5'd17;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] digest_words(input mode_e m);
    logic [3:0] d;
    case (m)
      MODE_SHA3_224: d = 4'd4;
      MODE_SHA3_256: d = 4'd4;
      MODE_SHA3_384: d = 4'd6;
      MODE_SHA3_512: d = 4'd8;
      default:       d = 4'd4;
    endcase
    return d;
  endfunction

  // State byte 0 (lane bits 7:0) becomes the most significant output byte.
  function automatic logic [KECCAK_LANE_W-1:0] lane_bswap(input logic [KECCAK_LANE_W-1:0] lane);
    logic [KECCAK_LANE_W-1:0] out;
    out = '0;
    for (int b = 0; b < 8; b++) begin
      out[8*b +: 8] = lane[56-8*b +: 8];
    end
    return out;
  endfunction

endpackage

// File: rtl/keccak_buffer_out.sv
// Output buffer of the Keccak core: snapshots the rate lanes on permutation
// completion and streams them as byte-swapped 64-bit words, squeezing for SHAKE.
module keccak_buffer_out
  import keccak_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int RATE_W = 1344,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmode,
  input  logic [LEN_W-1:0]  out_words,
  input  logic              load,
  input  logic [RATE_W-1:0] state_i,
  output logic [WORD_W-1:0] dt_o,
  output logic [7:0]        keep_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              squeeze_req,
  output logic              busy,
  output logic              done
);

  localparam int LANES = RATE_W / WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_PERM = 2'd2
  } state_e;

  state_e             state_reg, state_next;
  mode_e              mode_reg, mode_next;
  logic [4:0]         idx_reg, idx_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic               done_reg, done_next;
  logic               snap_load;
  logic [RATE_W-1:0]  snapshot_reg;

  logic [WORD_W-1:0]  lanes [LANES];
  logic [WORD_W-1:0]  lane_sel;
  logic               final_word;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lanes[gi] = snapshot_reg[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      if (idx_reg == 5'(k)) begin
        lane_sel = lanes[k];
      end
    end
  end

  // <= 1 rather than == 1 so a corrupted zero count can never wrap around.
  assign final_word = (remaining_reg <= LEN_W'(1));

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    idx_next       = idx_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    snap_load      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          snap_load  = 1'b1;
          mode_next  = decode_mode(cmode);
          idx_next   = 5'd0;
          state_next = ST_SEND;
          if (is_shake(decode_mode(cmode))) begin
            remaining_next = (out_words == '0) ? LEN_W'(1) : out_words;
          end else begin
            remaining_next = LEN_W'(digest_words(decode_mode(cmode)));
          end
        end
      end
      ST_SEND: begin
        if (ready_i) begin
          if (final_word) begin
            remaining_next = '0;
            idx_next       = 5'd0;
            done_next      = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            remaining_next = remaining_reg - LEN_W'(1);
            if (idx_reg == rate_words(mode_reg) - 5'd1) begin
              idx_next   = 5'd0;
              state_next = ST_WAIT_PERM;
            end else begin
              idx_next = idx_reg + 5'd1;
            end
          end
        end
      end
      ST_WAIT_PERM: begin
        if (load) begin
          snap_load  = 1'b1;
          idx_next   = 5'd0;
          state_next = ST_SEND;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_SHA3_224;
      idx_reg       <= 5'd0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      idx_reg       <= idx_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot_reg <= '0;
    end else if (snap_load) begin
      snapshot_reg <= state_i;
    end
  end

  // Word outputs are pure decodes of held registers, so they stay put under backpressure.
  assign valid_o     = (state_reg == ST_SEND);
  assign dt_o        = valid_o ? lane_bswap(lane_sel) : '0;
  assign last_o      = valid_o && final_word;
  assign keep_o      = !valid_o ? 8'h00 :
                       ((mode_reg == MODE_SHA3_224) && final_word) ? 8'hF0 : 8'hFF;
  assign squeeze_req = (state_reg == ST_WAIT_PERM);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_keccak_buffer_out.sv
// Scoreboard bench for keccak_buffer_out: expected words are queued when a
// snapshot is loaded and compared as the sink accepts them.
module tb_keccak_buffer_out;

  logic          clk;
  logic          rst_n;
  logic [2:0]    cmode;
  logic [15:0]   out_words;
  logic          load;
  logic [1343:0] state_i;
  logic [63:0]   dt_o;
  logic [7:0]    keep_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          squeeze_req;
  logic          busy;
  logic          done;

  keccak_buffer_out dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmode      (cmode),
    .out_words  (out_words),
    .load       (load),
    .state_i    (state_i),
    .dt_o       (dt_o),
    .keep_o     (keep_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .squeeze_req(squeeze_req),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dt;
    logic [7:0]  keep;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rate_tab[6]   = '{18, 17, 13, 9, 21, 17};
  int   digest_tab[6] = '{4, 4, 6, 8, 0, 0};

  logic       bp_en   = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         bp_cnt  = 0;
  logic       stall_prev = 1'b0;
  logic [63:0] stall_dt;
  logic [7:0]  stall_keep;
  logic        stall_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] swap_bytes(input logic [63:0] lane);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[63-8*b -: 8] = lane[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1343:0] rand_state();
    logic [1343:0] s;
    for (int i = 0; i < 42; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Queue the words one snapshot delivers; rem carries across squeezes.
  task automatic push_segment(input logic [1343:0] st, input int mode, inout int rem);
    exp_t e;
    int   n;
    n = rate_tab[mode];
    for (int i = 0; i < n && rem > 0; i++) begin
      e.dt   = swap_bytes(st[64*i +: 64]);
      e.keep = (mode == 0 && rem == 1) ? 8'hF0 : 8'hFF;
      e.last = (rem == 1);
      sb_q.push_back(e);
      rem--;
    end
  endtask

  task automatic pulse_load(input logic [2:0] m, input logic [15:0] ow,
                            input logic [1343:0] st, input bit immediate);
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    cmode = m; out_words = ow; state_i = st; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    state_i = rand_state();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (sb_q.size() != 0) begin
      check({tag, "_drain_timeout"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  // Called right after the last word was seen accepted: lands in the cycle after it.
  task automatic check_finish(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_valid_after"}, 64'(valid_o), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        ready_i = bp_pat[bp_cnt];
        bp_cnt  = (bp_cnt + 1) % 4;
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", 64'(valid_o), 64'd1);
        check("hold_dt", dt_o, stall_dt);
        check("hold_keep", 64'(keep_o), 64'(stall_keep));
        check("hold_last", 64'(last_o), 64'(stall_last));
      end
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 64'(dt_o), 64'hx);
        end else begin
          e = sb_q.pop_front();
          $display("word dt=%h keep=%h last=%0b exp_dt=%h", dt_o, keep_o, last_o, e.dt);
          check("dt_o", dt_o, e.dt);
          check("keep_o", 64'(keep_o), 64'(e.keep));
          check("last_o", 64'(last_o), 64'(e.last));
        end
      end
      stall_prev = valid_o && !ready_i;
      stall_dt   = dt_o;
      stall_keep = keep_o;
      stall_last = last_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    logic [1343:0] st, st_b;
    logic [63:0]   first_exp;
    int            rem;

    rst_n = 1'b0; load = 1'b0; cmode = 3'd0; out_words = 16'd0;
    state_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dt", dt_o, 64'd0);
    check("rst_keep", 64'(keep_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_squeeze", 64'(squeeze_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SHA3-256 of the empty message
    st = rand_state();
    st[63:0] = 64'h66d71ebff8c6ffa7;
    first_exp = 64'ha7ffc6f8bf1ed766;
    check("sha256_first_model", swap_bytes(st[63:0]), first_exp);
    rem = 4;
    push_segment(st, 1, rem);
    pulse_load(3'd1, 16'd0, st, 1'b0);
    check("sha256_valid_n1", 64'(valid_o), 64'd1);
    check("sha256_dt_n1", dt_o, first_exp);
    wait_drain("sha256", 40);
    check_finish("sha256");
    @(posedge clk);
    #1;
    check("sha256_done_pulse", 64'(done), 64'd0);

    // SHA3-224 truncation mask
    st = rand_state();
    rem = digest_tab[0];
    push_segment(st, 0, rem);
    pulse_load(3'd0, 16'd0, st, 1'b0);
    wait_drain("sha224", 40);
    check_finish("sha224");

    // SHAKE128, 25 words: full rate then one squeeze
    st = rand_state();
    rem = 25;
    push_segment(st, 4, rem);
    pulse_load(3'd4, 16'd25, st, 1'b0);
    wait_drain("shake128_a", 60);
    @(posedge clk);
    #1;
    check("shake128_squeeze", 64'(squeeze_req), 64'd1);
    check("shake128_valid_wait", 64'(valid_o), 64'd0);
    check("shake128_busy_wait", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("shake128_squeeze_held", 64'(squeeze_req), 64'd1);
    st = rand_state();
    st[63:0] = 64'h1;
    push_segment(st, 4, rem);
    check("shake128_second_first", sb_q[0].dt, 64'h0100000000000000);
    pulse_load(3'd0, 16'd3, st, 1'b0);
    check("shake128_reload_valid", 64'(valid_o), 64'd1);
    check("shake128_reload_squeeze", 64'(squeeze_req), 64'd0);
    wait_drain("shake128_b", 40);
    check_finish("shake128");

    // SHA3-512 under 1,0,0,1 backpressure
    bp_en = 1'b1; bp_cnt = 0;
    st = rand_state();
    rem = digest_tab[3];
    push_segment(st, 3, rem);
    pulse_load(3'd3, 16'd0, st, 1'b0);
    wait_drain("sha512_bp", 100);
    bp_en = 1'b0;
    check_finish("sha512_bp");

    // Stray load while sending is ignored
    bp_en = 1'b1; bp_cnt = 0;
    st = rand_state();
    st_b = rand_state();
    rem = 4;
    push_segment(st, 1, rem);
    pulse_load(3'd1, 16'd0, st, 1'b0);
    repeat (2) @(posedge clk);
    pulse_load(3'd4, 16'd9, st_b, 1'b0);
    check("stray_busy", 64'(busy), 64'd1);
    wait_drain("stray", 60);
    bp_en = 1'b0;
    check_finish("stray");

    // SHAKE256 with zero length, loaded in the done cycle
    st = rand_state();
    rem = 1;
    push_segment(st, 5, rem);
    pulse_load(3'd5, 16'd0, st, 1'b1);
    check("shake256_valid", 64'(valid_o), 64'd1);
    check("shake256_last", 64'(last_o), 64'd1);
    wait_drain("shake256", 20);
    check_finish("shake256");

    // Asynchronous reset while word 2 is on the bus
    st = rand_state();
    rem = 8;
    push_segment(st, 3, rem);
    pulse_load(3'd3, 16'd0, st, 1'b0);
    begin
      int k;
      k = 0;
      while (sb_q.size() > 6 && k < 20) begin
        @(negedge clk);
        #2;
        k++;
      end
    end
    check("abort_reached_word2", 64'(sb_q.size()), 64'd6);
    @(posedge clk);
    #2;
    check("abort_word2_visible", dt_o, swap_bytes(st[128 +: 64]));
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("abort_dt", dt_o, 64'd0);
    check("abort_keep", 64'(keep_o), 64'd0);
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_last", 64'(last_o), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_squeeze", 64'(squeeze_req), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from word 0; encoding 7 behaves as SHA3-256
    st = rand_state();
    rem = 4;
    push_segment(st, 1, rem);
    pulse_load(3'd7, 16'd0, st, 1'b0);
    check("restart_dt0", dt_o, swap_bytes(st[63:0]));
    wait_drain("restart", 40);
    check_finish("restart");

    repeat (3) @(posedge clk);
    #1;
    check("tail_no_words", 64'(sb_q.size()), 64'd0);
    check("tail_valid", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
